// File: rtl/wall_clock_ctrl.sv
// -----------------------------------------------------------------------------
// wall_clock_ctrl
//   Time-keeping controller for the WallClock top level. A prescaler makes the
//   one-second strobe. A small FSM owns the seconds / BCD minute / BCD hour
//   counters and shares them between that strobe and the IncMin / IncHour
//   button pulses. It applies one update per cycle.
//
//   Build option: define WALL_CLOCK_12H_EN for a 12-hour clock (12,01..11,12)
//   with a pm output. Without it the clock runs 00..23 and there is no pm port.
//
// Ports
//   CLK100MHZ  in   system clock, all state on the rising edge
//   reset_n    in   asynchronous active-low reset
//   run        in   1 = prescaler counts; 0 = prescaler frozen (buttons still work)
//   inc_min    in   single-cycle pulse, advance minutes (no hour carry)
//   inc_hour   in   single-cycle pulse, advance hours
//   seconds    out  binary seconds 0..59
//   mins1      out  BCD minutes units
//   mins2      out  BCD minutes tens
//   hours1     out  BCD hours units
//   hours2     out  BCD hours tens
//   sec_tick   out  high in the cycle the prescaler wraps
//   pm         out  (12h build only) toggles on every 11 -> 12 hour step
//   fsm_state  out  current FSM state, for debug and checker binding
// -----------------------------------------------------------------------------
module wall_clock_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int DIV_W    = 27
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [5:0] seconds,
  output logic [3:0] mins1,
  output logic [3:0] mins2,
  output logic [3:0] hours1,
  output logic [3:0] hours2,
  output logic       sec_tick,
`ifdef WALL_CLOCK_12H_EN
  output logic       pm,
`endif
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UPD_SEC   = 3'd1,
    CARRY_MIN = 3'd2,
    CARRY_HR  = 3'd3,
    UPD_MIN   = 3'd4,
    UPD_HOUR  = 3'd5
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_p, min_p, hour_p;
  logic             clr_tick, clr_min, clr_hour;
  logic             do_sec, do_min, do_hour;
  logic             sec_wrap, min_wrap;
  logic [3:0]       hr1_nxt, hr2_nxt;
`ifdef WALL_CLOCK_12H_EN
  logic             pm_flip;
`endif

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Prescaler. The strobe is decoded from the count so it is high in the same
  // cycle the count sits at its last value; the count wraps on that edge.
  // ---------------------------------------------------------------------------
  assign sec_tick = run && (div_cnt == DIV_LAST);

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= sec_tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags. A new event wins over a clear that lands in the same cycle,
  // so an event arriving just as its predecessor is serviced is not dropped.
  // A repeat event while the flag is still set simply merges into it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      tick_p <= 1'b0;
      min_p  <= 1'b0;
      hour_p <= 1'b0;
    end else begin
      tick_p <= sec_tick | (tick_p & ~clr_tick);
      min_p  <= inc_min  | (min_p  & ~clr_min);
      hour_p <= inc_hour | (hour_p & ~clr_hour);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign sec_wrap = (seconds == 6'd59);
  assign min_wrap = (mins2 == 4'd5) && (mins1 == 4'd9);

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_tick  = 1'b0;
    clr_min   = 1'b0;
    clr_hour  = 1'b0;
    do_sec    = 1'b0;
    do_min    = 1'b0;
    do_hour   = 1'b0;
    case (state)
      IDLE: begin
        // Tick first so wall time never drifts behind button activity.
        if (tick_p)      state_nxt = UPD_SEC;
        else if (min_p)  state_nxt = UPD_MIN;
        else if (hour_p) state_nxt = UPD_HOUR;
      end
      UPD_SEC: begin
        do_sec    = 1'b1;
        clr_tick  = 1'b1;
        state_nxt = sec_wrap ? CARRY_MIN : IDLE;
      end
      CARRY_MIN: begin
        do_min    = 1'b1;
        state_nxt = min_wrap ? CARRY_HR : IDLE;
      end
      CARRY_HR: begin
        do_hour   = 1'b1;
        state_nxt = IDLE;
      end
      UPD_MIN: begin
        // Button minute advance deliberately never carries into hours.
        do_min    = 1'b1;
        clr_min   = 1'b1;
        state_nxt = IDLE;
      end
      UPD_HOUR: begin
        do_hour   = 1'b1;
        clr_hour  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next hour value. Both digits are computed together so they change on the
  // same edge and no out-of-range digit is ever visible.
  // ---------------------------------------------------------------------------
  always_comb begin
    hr2_nxt = hours2;
    hr1_nxt = hours1 + 4'd1;
`ifdef WALL_CLOCK_12H_EN
    pm_flip = 1'b0;
    if (hours2 == 4'd1 && hours1 == 4'd2) begin
      hr2_nxt = 4'd0;
      hr1_nxt = 4'd1;
    end else if (hours2 == 4'd1 && hours1 == 4'd1) begin
      hr1_nxt = 4'd2;
      pm_flip = 1'b1;
    end else if (hours1 == 4'd9) begin
      hr2_nxt = 4'd1;
      hr1_nxt = 4'd0;
    end
`else
    if (hours2 == 4'd2 && hours1 == 4'd3) begin
      hr2_nxt = 4'd0;
      hr1_nxt = 4'd0;
    end else if (hours1 == 4'd9) begin
      hr2_nxt = hours2 + 4'd1;
      hr1_nxt = 4'd0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      seconds <= 6'd0;
      mins1   <= 4'd0;
      mins2   <= 4'd0;
`ifdef WALL_CLOCK_12H_EN
      hours2  <= 4'd1;
      hours1  <= 4'd2;
      pm      <= 1'b0;
`else
      hours2  <= 4'd0;
      hours1  <= 4'd0;
`endif
    end else begin
      if (do_sec) begin
        seconds <= sec_wrap ? 6'd0 : seconds + 6'd1;
      end
      if (do_min) begin
        if (mins1 == 4'd9) begin
          mins1 <= 4'd0;
          mins2 <= (mins2 == 4'd5) ? 4'd0 : mins2 + 4'd1;
        end else begin
          mins1 <= mins1 + 4'd1;
        end
      end
      if (do_hour) begin
        hours2 <= hr2_nxt;
        hours1 <= hr1_nxt;
`ifdef WALL_CLOCK_12H_EN
        if (pm_flip) pm <= ~pm;
`endif
      end
    end
  end

endmodule

// File: tb/tb_wall_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wall_clock_ctrl
//   Bench for wall_clock_ctrl with TICK_DIV=4. The reference keeps wall time as
//   plain integers (s, m, h) and schedules each serviced event as a short list
//   of timed updates: a tick updates seconds two edges after it is sampled,
//   then minutes and hours on the following edges if they wrap. Buttons behave
//   the same way without a carry. All outputs are compared against it on every
//   falling edge. Directed scenarios add literal pins at known edges.
// -----------------------------------------------------------------------------
module tb_wall_clock_ctrl;

  localparam int TICK_DIV = 4;
`ifdef WALL_CLOCK_12H_EN
  localparam int H_RST = 12;
  localparam int H_PRE = 11;
`else
  localparam int H_RST = 0;
  localparam int H_PRE = 23;
`endif

  localparam int A_NONE = 0, A_SEC = 1, A_CMIN = 2, A_CHR = 3, A_MIN = 4, A_HOUR = 5;

  // ---------------- clock / reset ----------------
  logic       CLK100MHZ = 1'b0;
  logic       reset_n, run, inc_min, inc_hour;
  logic [5:0] seconds;
  logic [3:0] mins1, mins2, hours1, hours2;
  logic       sec_tick;
  logic [2:0] fsm_state;
`ifdef WALL_CLOCK_12H_EN
  logic       pm;
`endif

  always #5 CLK100MHZ = ~CLK100MHZ;

  wall_clock_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(3)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .run       (run),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .seconds   (seconds),
    .mins1     (mins1),
    .mins2     (mins2),
    .hours1    (hours1),
    .hours2    (hours2),
    .sec_tick  (sec_tick),
`ifdef WALL_CLOCK_12H_EN
    .pm        (pm),
`endif
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int ps, s, m, h;
  bit pmv;
  bit tp, mp, hp;
  int edge_no = 0;
  int act_kind, act_edge;

  task automatic model_reset();
    ps = 0; s = 0; m = 0; h = H_RST; pmv = 1'b0;
    tp = 1'b0; mp = 1'b0; hp = 1'b0;
    act_kind = A_NONE; act_edge = 0;
  endtask

  task automatic hour_step();
`ifdef WALL_CLOCK_12H_EN
    if (h == 11) pmv = ~pmv;
    h = (h % 12) + 1;
`else
    h = (h + 1) % 24;
`endif
  endtask

  // Advance the model over one rising edge, given the inputs held before it.
  task automatic model_edge(input bit r, input bit im, input bit ih);
    bit tev, otp, omp, ohp, ctp, cmp, chp;
    int kind;
    edge_no++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tev = r && (ps == TICK_DIV - 1);
    otp = tp; omp = mp; ohp = hp;
    ctp = 1'b0; cmp = 1'b0; chp = 1'b0;
    if (act_kind != A_NONE && act_edge == edge_no) begin
      kind     = act_kind;
      act_kind = A_NONE;
      case (kind)
        A_SEC: begin
          ctp = 1'b1;
          if (s == 59) begin s = 0; act_kind = A_CMIN; act_edge = edge_no + 1; end
          else s++;
        end
        A_CMIN: begin
          if (m == 59) begin m = 0; act_kind = A_CHR; act_edge = edge_no + 1; end
          else m++;
        end
        A_CHR:  hour_step();
        A_MIN:  begin cmp = 1'b1; m = (m + 1) % 60; end
        A_HOUR: begin chp = 1'b1; hour_step(); end
        default: ;
      endcase
    end else if (act_kind == A_NONE) begin
      if (otp)      begin act_kind = A_SEC;  act_edge = edge_no + 1; end
      else if (omp) begin act_kind = A_MIN;  act_edge = edge_no + 1; end
      else if (ohp) begin act_kind = A_HOUR; act_edge = edge_no + 1; end
    end
    tp = tev | (otp & ~ctp);
    mp = im  | (omp & ~cmp);
    hp = ih  | (ohp & ~chp);
    if (r) ps = (ps == TICK_DIV - 1) ? 0 : ps + 1;
  endtask

  // ---------------- compare ----------------
  task automatic compare_all();
    chk("seconds",  int'(seconds),  s);
    chk("mins1",    int'(mins1),    m % 10);
    chk("mins2",    int'(mins2),    m / 10);
    chk("hours1",   int'(hours1),   h % 10);
    chk("hours2",   int'(hours2),   h / 10);
    chk("sec_tick", int'(sec_tick), (reset_n && run && ps == TICK_DIV - 1) ? 1 : 0);
`ifdef WALL_CLOCK_12H_EN
    chk("pm",       int'(pm),       int'(pmv));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit r, input bit im, input bit ih);
    run = r; inc_min = im; inc_hour = ih;
    @(negedge CLK100MHZ);
    compare_all();
    @(posedge CLK100MHZ);
    model_edge(r, im, ih);
    #1;
  endtask

  task automatic press_min();
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_hour();
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic mins_to(input int target);
    int n = 0;
    while (m != target && n < 70) begin press_min(); n++; end
    if (m != target) chk("mins_to_timeout", m, target);
  endtask

  task automatic hours_to(input int target);
    int n = 0;
    while (h != target && n < 30) begin press_hour(); n++; end
    if (h != target) chk("hours_to_timeout", h, target);
  endtask

  // Run until seconds sit at 59, the controller is quiet and the next edge samples a tick.
  task automatic run_to_tick59();
    int n = 0;
    while (!(s == 59 && ps == TICK_DIV - 1 && act_kind == A_NONE && !tp) && n < 400) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    if (n >= 400) chk("run_to_tick59_timeout", s, 59);
  endtask

  task automatic pin_hours(input string name, input int hh);
    chk({name, "_h2"}, int'(hours2), hh / 10);
    chk({name, "_h1"}, int'(hours1), hh % 10);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; run = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset values, literal
    chk("rst_seconds", int'(seconds), 0);
    chk("rst_mins",    int'({mins2, mins1}), 0);
    pin_hours("rst", H_RST);
    chk("rst_fsm_idle", int'(fsm_state), 0);
    reset_n = 1'b1;

    // 240 cycles of run: 59 ticks serviced, minutes untouched
    repeat (240) step(1'b1, 1'b0, 1'b0);
    chk("run240_seconds", int'(seconds), 59);
    chk("run240_mins1",   int'(mins1), 0);
    chk("run240_mins2",   int'(mins2), 0);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Preload the last second of the day and roll it over
    hours_to(H_PRE);
    mins_to(59);
    run_to_tick59();
    pin_hours("pre", H_PRE);
    chk("pre_mins",    int'({mins2, mins1}), 8'h59);
    chk("pre_seconds", int'(seconds), 59);
    step(1'b1, 1'b0, 1'b0);                      // edge N samples the tick
    step(1'b0, 1'b0, 1'b0);                      // N+1
    step(1'b0, 1'b0, 1'b0);                      // N+2 seconds
    chk("roll_n2_seconds", int'(seconds), 0);
    chk("roll_n2_mins",    int'({mins2, mins1}), 8'h59);
    step(1'b0, 1'b0, 1'b0);                      // N+3 minutes
    chk("roll_n3_mins", int'({mins2, mins1}), 0);
    pin_hours("roll_n3", H_PRE);
    step(1'b0, 1'b0, 1'b0);                      // N+4 hours
    pin_hours("roll_n4", H_PRE == 23 ? 0 : 12);
`ifdef WALL_CLOCK_12H_EN
    chk("roll_pm", int'(pm), 1);
`endif
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Button minutes wrap without hour carry
    mins_to(59);
    press_min();
    chk("btn_min_wrap", int'({mins2, mins1}), 0);
    pin_hours("btn_min_nocarry", H_PRE == 23 ? 0 : 12);

    // Button hours: 09->10 and the top wrap
`ifdef WALL_CLOCK_12H_EN
    press_hour();
    pin_hours("h12_to_01", 1);
    hours_to(9);
    press_hour();
    pin_hours("h09_to_10", 10);
    hours_to(11);
    press_hour();
    pin_hours("h11_to_12", 12);
    chk("h11_to_12_pm", int'(pm), 0);
`else
    hours_to(9);
    press_hour();
    pin_hours("h09_to_10", 10);
    hours_to(19);
    press_hour();
    pin_hours("h19_to_20", 20);
    hours_to(23);
    press_hour();
    pin_hours("h23_to_00", 0);
`endif

    // Tick, minute and hour in one cycle: serviced in that order
    begin
      int n = 0;
      while (ps != TICK_DIV - 1 && n < 10) begin step(1'b0 == 1'b1 ? 1'b0 : 1'b1, 1'b0, 1'b0); n++; end
      if (ps != TICK_DIV - 1) chk("align_timeout", ps, TICK_DIV - 1);
    end
    step(1'b1, 1'b1, 1'b1);                      // N
    step(1'b0, 1'b0, 1'b0);                      // N+1
    step(1'b0, 1'b0, 1'b0);                      // N+2
    chk("all3_n2_seconds", int'(seconds), 1);
    chk("all3_n2_mins",    int'(mins1), 0);
    step(1'b0, 1'b0, 1'b0);                      // N+3
    chk("all3_n3_mins",    int'(mins1), 0);
    step(1'b0, 1'b0, 1'b0);                      // N+4
    chk("all3_n4_mins",    int'(mins1), 1);
    pin_hours("all3_n4", H_PRE == 23 ? 0 : 12);
    step(1'b0, 1'b0, 1'b0);                      // N+5
    step(1'b0, 1'b0, 1'b0);                      // N+6
    pin_hours("all3_n6", 1);

    // Two minute pulses during a carry chain merge into one increment
    run_to_tick59();
    step(1'b1, 1'b0, 1'b0);                      // N tick
    step(1'b1, 1'b1, 1'b0);                      // N+1 pulse
    step(1'b1, 1'b0, 1'b0);                      // N+2
    step(1'b0, 1'b1, 1'b0);                      // N+3 pulse, still pending
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("merge_mins",    int'({mins2, mins1}), 8'h03);
    chk("merge_seconds", int'(seconds), 0);

    // Reset in the middle of a minute carry discards it
    run_to_tick59();
    step(1'b1, 1'b0, 1'b0);                      // N tick
    step(1'b0, 1'b0, 1'b0);                      // N+1
    step(1'b0, 1'b0, 1'b0);                      // N+2: now carrying minutes
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_seconds", int'(seconds), 0);
    chk("midrst_mins",    int'({mins2, mins1}), 0);
    pin_hours("midrst", H_RST);
    chk("midrst_fsm_idle", int'(fsm_state), 0);
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("midrst_after_mins", int'({mins2, mins1}), 0);
    chk("midrst_after_secs", int'(seconds), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
      end
      step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
